// File: rtl/wb_write_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_write_ctrl_if                                           |
// | Description : Load/ALU result handshakes, register-file write port and   |
// |               decode hazard lookup for wb_write_ctrl. Forwarding data    |
// |               signals exist only when WB_FWD_EN is defined.              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface wb_write_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_ws;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_ready;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_ws;
    logic [DATA_W-1:0] alu_wd;
    logic              alu_ready;

    logic              WB_regwrite;
    logic [ADDR_W-1:0] ws;
    logic [DATA_W-1:0] wd;

    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [7:0]        stall_cnt;

`ifdef WB_FWD_EN
    logic [DATA_W-1:0] rs1_fwd_data;
    logic [DATA_W-1:0] rs2_fwd_data;

    modport master (
        output mem_valid, mem_ws, mem_wd, alu_valid, alu_ws, alu_wd, rs1, rs2,
        input  mem_ready, alu_ready, WB_regwrite, ws, wd,
        input  rs1_pending, rs2_pending, stall_cnt, rs1_fwd_data, rs2_fwd_data
    );

    modport slave (
        input  mem_valid, mem_ws, mem_wd, alu_valid, alu_ws, alu_wd, rs1, rs2,
        output mem_ready, alu_ready, WB_regwrite, ws, wd,
        output rs1_pending, rs2_pending, stall_cnt, rs1_fwd_data, rs2_fwd_data
    );
`else
    modport master (
        output mem_valid, mem_ws, mem_wd, alu_valid, alu_ws, alu_wd, rs1, rs2,
        input  mem_ready, alu_ready, WB_regwrite, ws, wd,
        input  rs1_pending, rs2_pending, stall_cnt
    );

    modport slave (
        input  mem_valid, mem_ws, mem_wd, alu_valid, alu_ws, alu_wd, rs1, rs2,
        output mem_ready, alu_ready, WB_regwrite, ws, wd,
        output rs1_pending, rs2_pending, stall_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/wb_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_write_ctrl                                              |
// | Description : Write-back arbiter: buffers load/ALU results in a FIFO and |
// |               retires one per cycle to the register file, with hazard    |
// |               lookup. Define WB_FWD_EN to add youngest-match forwarding. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module wb_write_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    wb_write_ctrl_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [c_CNT_W-1:0] count_q,     count_d;
    logic [c_PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic [ADDR_W-1:0]  ws_q,        ws_d;
    logic [DATA_W-1:0]  wd_q,        wd_d;
    logic [7:0]         stall_cnt_q, stall_cnt_d;

    logic [ADDR_W-1:0]  buf_ws_q [DEPTH];
    logic [ADDR_W-1:0]  buf_ws_d [DEPTH];
    logic [DATA_W-1:0]  buf_wd_q [DEPTH];
    logic [DATA_W-1:0]  buf_wd_d [DEPTH];

    logic               w_mem_ready;
    logic               w_alu_ready;
    logic               w_mem_acc;
    logic               w_alu_acc;
    logic               w_pop;
    logic               w_stall;
    logic [c_PTR_W-1:0] w_wr_alu;
    logic               w_rs1_pending;
    logic               w_rs2_pending;

    // Readiness looks only at current occupancy, never at this cycle's dequeue.
    assign w_mem_ready = !reset && ({1'b0, count_q} < c_DEPTH);
    assign w_alu_ready = !reset &&
                         (({1'b0, count_q} + (c_CNT_W + 1)'(bus.mem_valid)) < c_DEPTH);
    assign w_mem_acc   = bus.mem_valid && w_mem_ready;
    assign w_alu_acc   = bus.alu_valid && w_alu_ready;
    assign w_pop       = (count_q != '0);
    assign w_stall     = (bus.mem_valid && !w_mem_ready) || (bus.alu_valid && !w_alu_ready);
    assign w_wr_alu    = wr_ptr_q + c_PTR_W'(w_mem_acc);

    always_comb begin
        buf_ws_d      = buf_ws_q;
        buf_wd_d      = buf_wd_q;
        wr_ptr_d      = wr_ptr_q + c_PTR_W'(w_mem_acc) + c_PTR_W'(w_alu_acc);
        rd_ptr_d      = rd_ptr_q + c_PTR_W'(w_pop);
        count_d       = count_q + c_CNT_W'(w_mem_acc) + c_CNT_W'(w_alu_acc)
                        - c_CNT_W'(w_pop);
        wb_regwrite_d = w_pop;
        ws_d          = ws_q;
        wd_d          = wd_q;
        stall_cnt_d   = stall_cnt_q;

        // The mem result is older than the alu result accepted alongside it.
        if (w_mem_acc) begin
            buf_ws_d[wr_ptr_q] = bus.mem_ws;
            buf_wd_d[wr_ptr_q] = bus.mem_wd;
        end
        if (w_alu_acc) begin
            buf_ws_d[w_wr_alu] = bus.alu_ws;
            buf_wd_d[w_wr_alu] = bus.alu_wd;
        end

        if (w_pop) begin
            ws_d = buf_ws_q[rd_ptr_q];
            wd_d = buf_wd_q[rd_ptr_q];
        end

        if (w_stall && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

`ifdef WB_FWD_EN
    logic [DATA_W-1:0] w_rs1_fwd;
    logic [DATA_W-1:0] w_rs2_fwd;
`endif

    // Scan oldest (output stage) to youngest (tail) so the last match wins.
    always_comb begin
        w_rs1_pending = wb_regwrite_q && (ws_q == bus.rs1);
        w_rs2_pending = wb_regwrite_q && (ws_q == bus.rs2);
`ifdef WB_FWD_EN
        w_rs1_fwd = w_rs1_pending ? wd_q : '0;
        w_rs2_fwd = w_rs2_pending ? wd_q : '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((c_CNT_W'(k) < count_q) && (buf_ws_q[rd_ptr_q + c_PTR_W'(k)] == bus.rs1)) begin
                w_rs1_pending = 1'b1;
`ifdef WB_FWD_EN
                w_rs1_fwd = buf_wd_q[rd_ptr_q + c_PTR_W'(k)];
`endif
            end
            if ((c_CNT_W'(k) < count_q) && (buf_ws_q[rd_ptr_q + c_PTR_W'(k)] == bus.rs2)) begin
                w_rs2_pending = 1'b1;
`ifdef WB_FWD_EN
                w_rs2_fwd = buf_wd_q[rd_ptr_q + c_PTR_W'(k)];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wb_regwrite_q <= 1'b0;
            ws_q          <= '0;
            wd_q          <= '0;
            stall_cnt_q   <= '0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wb_regwrite_q <= wb_regwrite_d;
            ws_q          <= ws_d;
            wd_q          <= wd_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Storage needs no reset: entries are qualified by count and pointers.
    always_ff @(posedge clk) begin
        buf_ws_q <= buf_ws_d;
        buf_wd_q <= buf_wd_d;
    end

    assign bus.mem_ready   = w_mem_ready;
    assign bus.alu_ready   = w_alu_ready;
    assign bus.WB_regwrite = wb_regwrite_q;
    assign bus.ws          = ws_q;
    assign bus.wd          = wd_q;
    assign bus.rs1_pending = w_rs1_pending;
    assign bus.rs2_pending = w_rs2_pending;
    assign bus.stall_cnt   = stall_cnt_q;
`ifdef WB_FWD_EN
    assign bus.rs1_fwd_data = w_rs1_fwd;
    assign bus.rs2_fwd_data = w_rs2_fwd;
`endif
endmodule
`default_nettype wire
